// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDR  = 2;

  typedef logic [DEF_ADDR-1:0]  addr_t;
  typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: write bypass, busy bypass and reset masking.
// Optional macro REGFILE_ZERO_REG_EN forces address 0 to read as zero/not-busy.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR,
  parameter int DEPTH = 2 ** ADDR
) (
  input  logic                        rst,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy_vec,
  input  logic [ADDR-1:0]             addr,
  input  logic                        write_en,
  input  logic [ADDR-1:0]             write_addr,
  input  logic [WIDTH-1:0]            write_data,
  output logic [WIDTH-1:0]            data,
  output logic                        busy
);

  logic zero_hit;

`ifdef REGFILE_ZERO_REG_EN
  assign zero_hit = (addr == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // A pending write retires its producer, so the bypassed busy is always 0.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (!rst && !zero_hit) begin
      if (write_en && (write_addr == addr)) begin
        data = write_data;
      end else begin
        data = regs[addr];
        busy = busy_vec[addr];
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with two bypassed read ports, one write port and a busy scoreboard.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writeEnable,
  input  logic [ADDR-1:0]  writeAddr,
  input  logic [WIDTH-1:0] dIn,
  input  logic             reserveEnable,
  input  logic [ADDR-1:0]  reserveAddr,
  input  logic [ADDR-1:0]  readAddrA,
  input  logic [ADDR-1:0]  readAddrB,
  output logic [WIDTH-1:0] dOutA,
  output logic [WIDTH-1:0] dOutB,
  output logic             busyA,
  output logic             busyB
);

  localparam int DEPTH = 2 ** ADDR;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            write_hit;
  logic [DEPTH-1:0]            reserve_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
`ifdef REGFILE_ZERO_REG_EN
      if (gi == 0) begin : g_zero
        assign write_hit[gi]   = 1'b0;
        assign reserve_hit[gi] = 1'b0;
      end else begin : g_norm
        assign write_hit[gi]   = writeEnable && (writeAddr == ADDR'(gi));
        assign reserve_hit[gi] = reserveEnable && (reserveAddr == ADDR'(gi));
      end
`else
      assign write_hit[gi]   = writeEnable && (writeAddr == ADDR'(gi));
      assign reserve_hit[gi] = reserveEnable && (reserveAddr == ADDR'(gi));
`endif
    end
  endgenerate

  // Reserve is applied after the write clear so a new producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (write_hit[i]) regs[i] <= dIn;
      end
      busy <= (busy & ~write_hit) | reserve_hit;
    end
  end

  rf_read_port #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) u_port_a (
    .rst        (rst),
    .regs       (regs),
    .busy_vec   (busy),
    .addr       (readAddrA),
    .write_en   (writeEnable),
    .write_addr (writeAddr),
    .write_data (dIn),
    .data       (dOutA),
    .busy       (busyA)
  );

  rf_read_port #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) u_port_b (
    .rst        (rst),
    .regs       (regs),
    .busy_vec   (busy),
    .addr       (readAddrB),
    .write_en   (writeEnable),
    .write_addr (writeAddr),
    .write_data (dIn),
    .data       (dOutB),
    .busy       (busyB)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: vector table, directed corner cases, random vs model.
module tb_reg_file_2r1w;
  import regfile_pkg::*;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst;
  logic  we, re;
  addr_t wa, res, ra, rb;
  word_t din;
  word_t dOutA, dOutB;
  logic  busyA, busyB;

  int tests = 0;
  int fails = 0;

  word_t mem [4];
  logic  bsy [4];

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(8), .ADDR(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .writeEnable   (we),
    .writeAddr     (wa),
    .dIn           (din),
    .reserveEnable (re),
    .reserveAddr   (res),
    .readAddrA     (ra),
    .readAddrB     (rb),
    .dOutA         (dOutA),
    .dOutB         (dOutB),
    .busyA         (busyA),
    .busyB         (busyB)
  );

  typedef struct {
    logic  we;
    addr_t wa;
    word_t din;
    logic  re;
    addr_t res;
    addr_t ra;
    addr_t rb;
    word_t ea;
    word_t eb;
    logic  ba;
    logic  bb;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic w, addr_t a, word_t d, addr_t xa, addr_t xb, word_t ya, word_t yb);
    vec_t v;
    v.we = w; v.wa = a; v.din = d; v.re = 1'b0; v.res = '0;
    v.ra = xa; v.rb = xb; v.ea = ya; v.eb = yb; v.ba = 1'b0; v.bb = 1'b0;
    return v;
  endfunction

  function automatic word_t zfix(addr_t a, word_t v);
    return (ZERO_EN && a == 2'd0) ? 8'h00 : v;
  endfunction

  // Reference model: what a read shows right now, from state plus pending write.
  function automatic word_t m_data(addr_t a);
    if (rst) return 8'h00;
    if (ZERO_EN && a == 2'd0) return 8'h00;
    if (we && wa == a) return din;
    return mem[a];
  endfunction

  function automatic logic m_busy(addr_t a);
    if (rst) return 1'b0;
    if (ZERO_EN && a == 2'd0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return bsy[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'h00;
      bsy[i] = 1'b0;
    end
  endtask

  task automatic tick();
    if (rst) begin
      model_clear();
    end else begin
      if (we && !(ZERO_EN && wa == 2'd0)) mem[wa] = din;
      if (we) bsy[wa] = 1'b0;
      if (re && !(ZERO_EN && res == 2'd0)) bsy[res] = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drive(logic w, addr_t a, word_t d, logic r, addr_t ar, addr_t xa, addr_t xb);
    we = w; wa = a; din = d; re = r; res = ar; ra = xa; rb = xb;
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, "_dOutA"}, 32'(dOutA), 32'(m_data(ra)));
    check({tag, "_dOutB"}, 32'(dOutB), 32'(m_data(rb)));
    check({tag, "_busyA"}, 32'(busyA), 32'(m_busy(ra)));
    check({tag, "_busyB"}, 32'(busyB), 32'(m_busy(rb)));
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill and read-back, invert pass, rewrite and read-back.
    for (int i = 0; i < 4; i++) begin
      vecs[i]      = mk(1'b1, addr_t'(i), word_t'(i), addr_t'(i), addr_t'(i), word_t'(i), word_t'(i));
      vecs[4 + i]  = mk(1'b0, 2'd0, 8'h00, addr_t'(i), addr_t'(3 - i), word_t'(i), word_t'(3 - i));
      vecs[8 + i]  = mk(1'b1, addr_t'(3 - i), ~word_t'(3 - i), addr_t'(3 - i), addr_t'(3 - i),
                        ~word_t'(3 - i), ~word_t'(3 - i));
      vecs[16 + i] = mk(1'b1, addr_t'(i), word_t'(i), addr_t'(i), addr_t'(i), word_t'(i), word_t'(i));
      vecs[20 + i] = mk(1'b0, 2'd0, 8'h00, addr_t'(i), addr_t'(3 - i), word_t'(i), word_t'(3 - i));
    end
    vecs[12] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 8'hFF, 8'hFF);
    vecs[13] = mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd1, 8'hFE, 8'hFE);
    vecs[14] = mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 8'hFD, 8'hFD);
    vecs[15] = mk(1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 8'hFC, 8'hFC);

    model_clear();
    rst = 1'b1;
    drive(1'b1, 2'd1, 8'hAA, 1'b1, 2'd1, 2'd1, 2'd1);
    check("rst_dOutA", 32'(dOutA), 32'h0);
    check("rst_dOutB", 32'(dOutB), 32'h0);
    check("rst_busyA", 32'(busyA), 32'h0);
    check("rst_busyB", 32'(busyB), 32'h0);
    $display("[TB] reset held with write pending: dOutA=%h busyA=%b", dOutA, busyA);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd1);
    check("rst_nowrite_dOutA", 32'(dOutA), 32'h0);
    check("rst_noreserve_busyA", 32'(busyA), 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("pulse_dOutA", 32'(dOutA), 32'h0);
    rst = 1'b0;
    #1;
    $display("[TB] mid-cycle reset pulse done");

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].din, vecs[i].re, vecs[i].res, vecs[i].ra, vecs[i].rb);
      check($sformatf("vec%0d_dOutA", i), 32'(dOutA), 32'(zfix(vecs[i].ra, vecs[i].ea)));
      check($sformatf("vec%0d_dOutB", i), 32'(dOutB), 32'(zfix(vecs[i].rb, vecs[i].eb)));
      check($sformatf("vec%0d_busyA", i), 32'(busyA), 32'(vecs[i].ba));
      check($sformatf("vec%0d_busyB", i), 32'(busyB), 32'(vecs[i].bb));
      $display("[TB] vec %0d we=%b wa=%0d din=%h ra=%0d rb=%0d -> A=%h B=%h",
               i, vecs[i].we, vecs[i].wa, vecs[i].din, vecs[i].ra, vecs[i].rb, dOutA, dOutB);
      tick();
    end

    // Write bypass on the same cycle, then visible from storage afterwards.
    drive(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd2, 2'd1);
    check("byp_dOutA", 32'(dOutA), 32'hA5);
    check("byp_dOutB_other", 32'(dOutB), 32'h01);
    $display("[TB] bypass write 2<=a5: A=%h B=%h", dOutA, dOutB);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd2);
    check("byp_after_dOutB", 32'(dOutB), 32'hA5);
    $display("[TB] after edge B=%h", dOutB);

    // Scoreboard: reserve is not bypassed, write clears with bypass.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd1, 2'd1);
    check("sb_res_nobypass", 32'(busyA), 32'h0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd1);
    check("sb_res_busyA", 32'(busyA), 32'h1);
    check("sb_res_busyB", 32'(busyB), 32'h1);
    drive(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 2'd1, 2'd2);
    check("sb_wr_bypass_busy", 32'(busyA), 32'h0);
    check("sb_wr_bypass_data", 32'(dOutA), 32'h11);
    check("sb_other_busyB", 32'(busyB), 32'h0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd1);
    check("sb_wr_after_busy", 32'(busyA), 32'h0);
    check("sb_wr_after_data", 32'(dOutA), 32'h11);
    $display("[TB] scoreboard reserve/retire addr1: busyA=%b dOutA=%h", busyA, dOutA);
    drive(1'b1, 2'd3, 8'h33, 1'b1, 2'd3, 2'd3, 2'd3);
    check("sb_same_pre_busy", 32'(busyA), 32'h0);
    check("sb_same_pre_data", 32'(dOutA), 32'h33);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd3);
    check("sb_same_busy", 32'(busyA), 32'h1);
    check("sb_same_data", 32'(dOutA), 32'h33);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd3);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd3);
    check("sb_rereserve_busy", 32'(busyA), 32'h1);
    drive(1'b1, 2'd3, 8'h3C, 1'b1, 2'd1, 2'd3, 2'd1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd1);
    check("sb_diff_wr_busy", 32'(busyA), 32'h0);
    check("sb_diff_res_busy", 32'(busyB), 32'h1);
    check("sb_diff_wr_data", 32'(dOutA), 32'h3C);
    $display("[TB] reserve+write same/diff addr: busy3=%b busy1=%b", busyA, busyB);

    // Async reset mid-operation with a write pending and busy bits set.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 2'd2);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd1);
    check("ar_pre_busy2", 32'(busyA), 32'h1);
    rst = 1'b1;
    drive(1'b1, 2'd2, 8'h55, 1'b1, 2'd3, 2'd2, 2'd3);
    check("ar_dOutA", 32'(dOutA), 32'h0);
    check("ar_dOutB", 32'(dOutB), 32'h0);
    check("ar_busyA", 32'(busyA), 32'h0);
    check("ar_busyB", 32'(busyB), 32'h0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, addr_t'(a), addr_t'(3 - a));
      check($sformatf("ar_post%0d_dOutA", a), 32'(dOutA), 32'h0);
      check($sformatf("ar_post%0d_dOutB", a), 32'(dOutB), 32'h0);
      check($sformatf("ar_post%0d_busyA", a), 32'(busyA), 32'h0);
      $display("[TB] post-reset read %0d: A=%h B=%h busyA=%b", a, dOutA, dOutB, busyA);
    end

    // Register 0 write+reserve in the same cycle.
    drive(1'b1, 2'd0, 8'h7E, 1'b1, 2'd0, 2'd0, 2'd0);
    check("z_byp_dOutA", 32'(dOutA), 32'(zfix(2'd0, 8'h7E)));
    check("z_byp_busyA", 32'(busyA), 32'h0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
    check("z_dOutA", 32'(dOutA), 32'(zfix(2'd0, 8'h7E)));
    check("z_busyA", 32'(busyA), ZERO_EN ? 32'h0 : 32'h1);
    $display("[TB] reg0 write/reserve: A=%h busyA=%b", dOutA, busyA);

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(39) == 0) begin
        rst = 1'b1;
        model_clear();
        #1;
        check_model($sformatf("rnd%0d_rst", n));
        rst = 1'b0;
      end
      drive(1'($urandom_range(1)), addr_t'($urandom_range(3)), word_t'($urandom_range(255)),
            1'($urandom_range(1)), addr_t'($urandom_range(3)),
            addr_t'($urandom_range(3)), addr_t'($urandom_range(3)));
      check_model($sformatf("rnd%0d", n));
      $display("[TB] rnd %0d we=%b wa=%0d din=%h re=%b res=%0d ra=%0d rb=%0d -> A=%h B=%h bA=%b bB=%b",
               n, we, wa, din, re, res, ra, rb, dOutA, dOutB, busyA, busyB);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Clocked, parametrised register file with two read ports and one write port, built for the CPU datapath. It replaces the single-read, level-written regFile.
- Registers store on the clock edge.
- Same-cycle writes are forwarded to both read ports.
- A per-register busy scoreboard lets issue logic detect pending producers.
- Sits between decode (read, reserve) and writeback (write).

Parameters:
- WIDTH, 8, data width of each register in bits.
- ADDR, 2, address width; the register count DEPTH is 2**ADDR.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- writeEnable  in  1  commits dIn to writeAddr at the next rising edge.
- writeAddr  in  ADDR  write target.
- dIn  in  WIDTH  write data.
- reserveEnable  in  1  marks reserveAddr busy at the next rising edge.
- reserveAddr  in  ADDR  register to mark busy.
- readAddrA  in  ADDR  read port A address.
- readAddrB  in  ADDR  read port B address.
- dOutA  out  WIDTH  read port A data, combinational.
- dOutB  out  WIDTH  read port B data, combinational.
- busyA  out  1  busy bit of readAddrA after bypass.
- busyB  out  1  busy bit of readAddrB after bypass.

Behaviour:
- Reset: asserting rst immediately clears all DEPTH registers to 0 and all busy bits to 0, independent of clk.
  - While rst is high: dOutA = dOutB = 0 and busyA = busyB = 0. The zero-output requirement applies regardless of addresses, including while writeEnable is high; the bypass is masked during reset.
  - Deassertion takes effect synchronously with the next edge. No write or reserve happens on an edge where rst is high.
- Write: on a rising edge with writeEnable=1, reg[writeAddr] <= dIn. There is no read-before-write hazard.
- Read: combinational with zero latency.
  - dOutX = dIn when writeEnable=1 and writeAddr==readAddrX (write bypass); otherwise reg[readAddrX].
  - Ports A and B are fully independent; both may read the same address.
- Scoreboard: one busy bit per register.
  - Rising edge with reserveEnable=1: busy[reserveAddr] <= 1.
  - Rising edge with writeEnable=1: busy[writeAddr] <= 0.
  - Reserve and write to the same address on the same edge: busy ends at 1, because a new producer overrides retirement. Data is still written.
  - Reserve and write to different addresses on the same edge: both take effect.
  - busyX bypass: busyX = 0 when writeEnable=1 and writeAddr==readAddrX; otherwise busy[readAddrX]. A reserve in the current cycle is not bypassed; it becomes visible after the edge.
- Re-reserving an already busy register leaves it busy, with no error. Writing a non-busy register is legal and leaves it non-busy.
- Wrap-around: addresses are exactly ADDR bits wide, so they cannot exceed DEPTH-1. No out-of-range handling is required.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including the bypass path.
  - Reserves of address 0 are ignored, so busy[0] is constantly 0.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Shared package regfile_pkg:
  - Default WIDTH/ADDR constants.
  - Typedef for the register address.
  - Typedef for the data word.
- Sub-module rf_read_port, instantiated twice (ports A and B):
  - Inputs: the register array, busy vector, read address, and write port signals.
  - Outputs: bypassed data and busy.
  - Applies the reset mask and REGFILE_ZERO_REG_EN masking.
- The top level holds the storage array, busy vector and the async reset.

Test Plan (WIDTH=8, ADDR=2):
- Reset and fill: pulse rst mid-cycle, then check dOutA=dOutB=0 and busyA=busyB=0. Write addr i with data i for i=0..3, then read A=i and B=3-i. Expect dOutA=i and dOutB=3-i.
- Invert pass: write addr i with ~i for i=3..0, then read all four through both ports. Expect 8'hFF, FE, FD, FC at addr 0..3. Then rewrite addr i with i and recheck, expecting i.
- Bypass: reg2=8'h02. In one cycle set writeEnable=1, writeAddr=2, dIn=8'hA5, readAddrA=2. Expect dOutA=8'hA5 before the edge, and dOutB=8'hA5 after the edge with readAddrB=2.
- Scoreboard: reserve addr1, then read A=1 and expect busyA=1. Write addr1 with 8'h11: expect busyA=0 in the same cycle (bypass) and busy[1]=0 after the edge. Reserve and write addr3 on the same edge: expect busy[3]=1 afterwards and dOut=written value.
- Async reset mid-operation: with regs holding 1..3 and busy[2]=1, assert rst between edges. Expect all dOut=0 and busy=0 immediately. After release, read all addrs and expect 0.
- REGFILE_ZERO_REG_EN defined: write 8'h7E to addr0, and reserve addr0 in the same cycle. Expect dOutA=0 (including during the bypass cycle) and busyA=0. Undefined: expect dOutA=8'h7E and busyA=1.
